// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels.
// Used by both the transmit and receive paths.
package uart_pkg;

  // Transmit frame states. PARITY is only reachable when the transmitter is
  // built with UART_TX_PARITY_EN defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Level the serial line rests at between frames (and the stop-bit level).
  localparam logic LINE_IDLE = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// Bit-time counter. Counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_end for one cycle on the last count of every bit period. Held at zero
// while disabled or restarting, so a new frame always begins a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count and end-of-bit pulse.
  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (restart || !en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      bit_end = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// UART transmit serializer: accepts a byte over valid/ready and sends
// start bit, data LSB-first, optional parity, then STOP_BITS stop bits.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN; PARITY_ODD
// then selects odd (1) or even (0) parity.
//
// Handshake: a byte is transferred on a rising clk edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE; tx_valid seen while a
// frame is in flight is ignored, and tx_data is only sampled at the transfer
// edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Elaboration-time parameter legality checks.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  // Bit index counter also counts stop bits, which never exceed DATA_BITS.
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign accept   = tx_valid && tx_ready;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (RST),
    .restart(accept),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  // Next-state, shift register, line level and completion pulse.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d  = LINE_IDLE;
        idx_d = '0;
        if (accept) begin
          state_d  = START;
          shift_d  = tx_data;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = LINE_IDLE;
`endif
            idx_d   = '0;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
          idx_d   = '0;
        end
      end
`endif
      STOP: begin
        tx_d = LINE_IDLE;
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Frame registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= LINE_IDLE;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table of frames with latency expectations, a
// serial-line monitor backed by an expected-byte queue, and hand-written
// sequences for back-to-back frames, reset mid-frame and two stop bits.
// Parity expectations follow UART_TX_PARITY_EN when the bundle is built with it.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT     = 1;
  localparam int STOP_RUN = 48;  // 0x55 with odd parity: parity bit 1 joins the stop run
`else
  localparam int PBIT     = 0;
  localparam int STOP_RUN = 32;
`endif
  localparam int FRAME_CYC  = (1 + 8 + PBIT + 1) * CPB;
  localparam int FRAME2_CYC = (1 + 8 + PBIT + 2) * CPB;

  typedef struct {
    logic [7:0] data;
    int         exp_lat;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] data2;
  logic       valid2;
  logic       tx_ready2;
  logic       tx2;
  logic       tx_busy2;
  logic       tx_done2;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  bit         mon_busy = 0;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk     (clk),
    .RST     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (2),
    .PARITY_ODD  (1)
  ) dut2 (
    .clk     (clk),
    .RST     (rst),
    .tx_data (data2),
    .tx_valid(valid2),
    .tx_ready(tx_ready2),
    .tx      (tx2),
    .tx_busy (tx_busy2),
    .tx_done (tx_done2)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Driver tasks; all entered at a falling edge.
  task automatic wait_ready();
    for (int i = 0; i < 1000; i++) begin
      if (tx_ready === 1'b1) return;
      @(negedge clk);
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d, output int acc);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(d);
    wait_ready();
    acc = cyc + 1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("accept_tx_low", tx, 0);
    check("accept_busy", tx_busy, 1);
    check("accept_not_ready", tx_ready, 0);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 600; i++) begin
      if (tx_done === 1'b1) begin
        dc = cyc;
        return;
      end
      @(negedge clk);
    end
    check("done_timeout", 0, 1);
  endtask

  // Serial-line monitor: decodes each frame on tx against the next expected byte.
  initial begin : monitor
    logic [7:0]  d;
    logic [11:0] fb;
    logic [7:0]  rxb;
    int          nb;
    int          bad;
    bit          ab;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          d = 8'h00;
        end else begin
          d = exp_q.pop_front();
        end
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^d;
        nb    = 11;
`else
        nb    = 10;
`endif
        bad = 0;
        rxb = '0;
        ab  = 0;
        for (int b = 0; b < nb; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst) begin
              ab = 1;
              break;
            end
            if (tx !== fb[b]) bad++;
            if (k == CPB / 2 && b >= 1 && b <= 8) rxb[b-1] = tx;
          end
          if (ab) break;
        end
        if (!ab) begin
          check("frame_data", rxb, d);
          check("frame_bit_errors", bad, 0);
        end
        mon_busy = 0;
      end
    end
  end

  // Main sequence
  initial begin
    vec_t vecs[8];
    int   acc;
    int   acc2;
    int   dc;
    int   last_low;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    valid2   = 1'b0;
    data2    = 8'h00;

    vecs[0] = '{8'hA5, FRAME_CYC};
    vecs[1] = '{8'h07, FRAME_CYC};
    vecs[2] = '{8'h00, FRAME_CYC};
    vecs[3] = '{8'hFF, FRAME_CYC};
    vecs[4] = '{8'h80, FRAME_CYC};
    for (int i = 5; i < 8; i++) vecs[i] = '{8'($urandom_range(0, 255)), FRAME_CYC};

    // Reset held, then idle line after release
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    end

    // Table of single frames
    foreach (vecs[i]) begin
      send(vecs[i].data, acc);
      wait_done(dc);
      check("latency", dc - acc, vecs[i].exp_lat);
      check("ready_at_done", tx_ready, 1);
      @(negedge clk);
      check("done_pulse_width", tx_done, 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // Back-to-back with tx_valid held; data switched after the first accept
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wait_ready();
    acc = cyc + 1;
    @(negedge clk);
    tx_data = 8'hFF;
    wait_done(dc);
    check("b2b_first_latency", dc - acc, FRAME_CYC);
    check("b2b_line_high_at_done", tx, 1);
    @(negedge clk);
    check("b2b_second_start_tx", tx, 0);
    check("b2b_second_busy", tx_busy, 1);
    acc2     = cyc;
    tx_valid = 1'b0;
    wait_done(dc);
    check("b2b_second_latency", dc - acc2, FRAME_CYC);
    @(negedge clk);

    // Reset during data bit 3 of 0xC3 (a zero bit)
    send(8'hC3, acc);
    while (cyc < acc + 70) @(negedge clk);
    check("pre_reset_tx_low", tx, 0);
    #2 rst = 1'b1;
    #1;
    check("reset_async_tx", tx, 1);
    check("reset_async_ready", tx_ready, 1);
    check("reset_async_busy", tx_busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_outputs", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_idle", {tx, tx_ready, tx_busy, tx_done}, 4'b1100);
    end
    send(8'h3C, acc);
    wait_done(dc);
    check("post_reset_latency", dc - acc, FRAME_CYC);
    @(negedge clk);

    // Two stop bits on the second instance
    data2  = 8'h55;
    valid2 = 1'b1;
    check("dut2_ready", tx_ready2, 1);
    acc2 = cyc + 1;
    @(negedge clk);
    valid2   = 1'b0;
    last_low = acc2;
    dc       = -1;
    for (int i = 0; i < 400; i++) begin
      if (tx2 === 1'b0) last_low = cyc;
      if (tx_done2 === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("dut2_latency", dc - acc2, FRAME2_CYC);
    check("dut2_stop_high_run", dc - last_low - 1, STOP_RUN);
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // Odd parity of 0x07 is 0
    data2  = 8'h07;
    valid2 = 1'b1;
    acc2   = cyc + 1;
    @(negedge clk);
    valid2 = 1'b0;
    while (cyc < acc2 + 9 * CPB + CPB / 2) @(negedge clk);
    check("dut2_odd_parity_bit", tx2, 0);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      if (tx_done2 === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("dut2_parity_latency", dc - acc2, FRAME2_CYC);
`endif

    // Drain the scoreboard
    for (int i = 0; i < 200 && (mon_busy || exp_q.size() != 0); i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer, the transmit end of the UART link. It accepts a parallel byte over a valid/ready handshake and drives the serial line: start bit, data LSB-first, optional parity, stop bit(s).
It is the counterpart of the receive path, whose one_shot start-bit detector keys on the falling edge this block produces. Line idles high.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (baud divisor); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..8
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  in  1  system clock, rising-edge
RST  in  1  asynchronous, active-high reset
tx_data  in  DATA_BITS  byte to send; sampled only on handshake
tx_valid  in  1  producer has data
tx_ready  out  1  block can accept; high only in IDLE
tx  out  1  serial line; registered; idle level 1
tx_busy  out  1  frame in progress (state != IDLE)
tx_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Clock and reset (fixed): single clock clk; RST asynchronous, active-high. While RST is high: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The frame is abandoned with no tx_done. After RST deasserts, the block is in IDLE with tx_ready=1.
- Handshake: transfer occurs on a rising edge where tx_valid && tx_ready.
  - At that edge: tx_data latches into the shift register, state -> START, tx -> 0, tx_ready -> 0, tx_busy -> 1.
  - tx_valid while busy is ignored. tx_data changes after acceptance have no effect.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: shift LSB first. Each bit lasts exactly CLKS_PER_BIT cycles. After DATA_BITS bits, go to PARITY (if enabled) or STOP.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then -> IDLE.
- Completion edge: at the edge ending the last stop bit, state -> IDLE, tx_ready -> 1, tx_busy -> 0, and tx_done = 1 for exactly one cycle.
- Latency: accept edge to completion edge = F*CLKS_PER_BIT cycles, where F = 1 + DATA_BITS + P + STOP_BITS and P = 1 if parity is enabled, else 0.
- Back-to-back frames (tx_valid held high): the next accept happens one edge after completion. The effective stop time is therefore STOP_BITS*CLKS_PER_BIT+1 cycles; frame period = F*CLKS_PER_BIT + 1.
- Counter widths:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit end.
  - Bit index counter: $clog2(DATA_BITS+1) bits.
  - No counter runs in IDLE.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a parity bit follows the data bits. Even parity = XOR of data bits; odd parity = its inverse (selected by PARITY_ODD). Parity is computed from the latched byte at the accept edge.
- Undefined: no PARITY state exists, PARITY_ODD is unused, and F = 1 + DATA_BITS + STOP_BITS.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP
  - constant LINE_IDLE = 1'b1
  - shared with the receive path
- Sub-module uart_baud_gen: bit-time counter.
  - Restarts on frame start; emits a one-cycle bit_end pulse every CLKS_PER_BIT cycles while enabled.
  - Also reusable by the receiver.

Test Plan:
- Reset: RST=1 for 5 cycles, release, idle 50 cycles -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no transitions on tx.
- Single frame, defaults (8N1, CLKS_PER_BIT=16), tx_data=0xA5 -> tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16. tx_done and tx_ready high exactly 160 cycles after the accept edge.
- Back-to-back: 0x00 then 0xFF with tx_valid held, tx_data switched mid-frame -> first frame carries 0x00. Second start bit begins 161 cycles after the first accept; the second frame carries 0xFF.
- Reset mid-frame: assert RST during data bit 3 of 0xC3 -> tx=1 in the same cycle, no tx_done. After release, frame 0x3C is sent cleanly with correct timing.
- Parity with UART_TX_PARITY_EN, tx_data=0x07:
  - PARITY_ODD=0 -> parity bit 1.
  - PARITY_ODD=1 -> parity bit 0.
  - tx_done at 176 cycles in both cases.
  - Without the macro, the same stimulus gives tx_done at 160.
- STOP_BITS=2, tx_data=0x55 -> stop level high for 32 cycles; tx_done at 176 cycles (without parity).
